bpu_gshare: RTL and testbench

Parametrised branch prediction unit for the 5-stage RV32I pipeline: gshare table of 2-bit saturating counters with global history, selectable index hash, hardware table initialisation after reset, optional return-address stack, and hit/branch statistics counters. The decode stage looks predictions up combinationally. The execute stage writes resolved outcomes back. Replaces the predictor previously inlined in the core.

---
 rtl/bpu_pkg.sv | 31 +++
 rtl/bpu_ras.sv | 79 +++++++
 rtl/bpu_gshare.sv | 162 ++++++++++++++++
 tb/tb_bpu_gshare.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared types and helpers for the gshare branch prediction unit.
// Holds the 2-bit counter encodings, the INIT/RUN state enum and the
// saturating counter update used when training the pattern table.
package bpu_pkg;

  // 2-bit saturating counter encodings
  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } bpu_state_e;

  // Move a counter one step towards the resolved direction, clamping at the ends
  function automatic logic [1:0] incdec_sat(input logic [1:0] prev, input logic dir);
    logic [1:0] res;
    res = prev;
    if (dir) begin
      if (prev != ST) res = prev + 2'd1;
      else            res = ST;
    end else begin
      if (prev != SNT) res = prev - 2'd1;
      else             res = SNT;
    end
    return res;
  endfunction

endpackage

// File: rtl/bpu_ras.sv
// Circular return-address stack. A push beyond capacity silently replaces
// the oldest entry; pops on an empty stack are dropped. A push together
// with a pop replaces the current top in place.
module bpu_ras #(
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push_i,
  input  logic [31:0] push_addr_i,
  input  logic        pop_i,
  output logic [31:0] target_o,
  output logic        valid_o
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);

  logic [31:0]   ent_q [RAS_DEPTH];
  logic [PW-1:0] top_q, top_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_en_s;
  logic [PW-1:0] wr_ptr_s;

  // Next top/count and entry write selection for push, pop and push+pop
  always_comb begin
    top_d    = top_q;
    cnt_d    = cnt_q;
    wr_en_s  = 1'b0;
    wr_ptr_s = top_q;
    case ({push_i, pop_i})
      2'b10: begin
        wr_en_s  = 1'b1;
        wr_ptr_s = top_q + PW'(1'b1);
        top_d    = top_q + PW'(1'b1);
        if (cnt_q != CNT_FULL) cnt_d = cnt_q + CW'(1'b1);
        else                   cnt_d = cnt_q;
      end
      2'b01: begin
        if (cnt_q != CW'(1'b0)) begin
          top_d = top_q - PW'(1'b1);
          cnt_d = cnt_q - CW'(1'b1);
        end else begin
          top_d = top_q;
          cnt_d = cnt_q;
        end
      end
      2'b11: begin
        wr_en_s  = 1'b1;
        wr_ptr_s = top_q;
        if (cnt_q == CW'(1'b0)) cnt_d = CW'(1'b1);
        else                    cnt_d = cnt_q;
      end
      default: begin
        top_d   = top_q;
        cnt_d   = cnt_q;
        wr_en_s = 1'b0;
      end
    endcase
  end

  // Stack pointer, occupancy and entry storage
  always_ff @(posedge clk) begin
    if (!resetn) begin
      top_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) ent_q[i] <= 32'd0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
      if (wr_en_s) ent_q[wr_ptr_s] <= push_addr_i;
    end
  end

  assign target_o = ent_q[top_q];
  assign valid_o  = (cnt_q != CW'(1'b0));

endmodule

// File: rtl/bpu_gshare.sv
// gshare branch direction predictor with global history, selectable index
// hash, a hardware sweep that initialises every counter after reset, and
// resolution statistics. Lookups are combinational from decode; training
// arrives from execute with the index captured at lookup time.
// Optional return-address stack: define BPU_RAS_EN.
module bpu_gshare
  import bpu_pkg::*;
#(
  parameter int unsigned HIST_BITS = 9,
  parameter int unsigned IDX_BITS  = 12,
  parameter int unsigned HASH_XOR  = 0,
  parameter logic [1:0]  CTR_INIT  = 2'b01,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic                clk,
  input  logic                resetn,
  output logic                ready,
  input  logic [31:0]         lk_pc,
  output logic                lk_taken,
  output logic [IDX_BITS-1:0] lk_index,
  input  logic                up_valid,
  input  logic [IDX_BITS-1:0] up_index,
  input  logic                up_taken,
  input  logic                up_predicted,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_hits
`ifdef BPU_RAS_EN
  ,
  input  logic                ras_push,
  input  logic [31:0]         ras_push_addr,
  input  logic                ras_pop,
  output logic [31:0]         ras_target,
  output logic                ras_valid
`endif
);

  localparam int unsigned TBL_SIZE = 1 << IDX_BITS;
  localparam logic [IDX_BITS-1:0] PTR_LAST = {IDX_BITS{1'b1}};

  logic [1:0]           tbl_q [TBL_SIZE];
  bpu_state_e           state_q, state_d;
  logic [IDX_BITS-1:0]  ptr_q, ptr_d;
  logic [HIST_BITS-1:0] ghr_q, ghr_d;
  logic [HIST_BITS-1:0] ghr_shift_s;
  logic [31:0]          br_q, br_d;
  logic [31:0]          hit_q, hit_d;
  logic                 wr_en_s;
  logic [IDX_BITS-1:0]  wr_addr_s;
  logic [1:0]           wr_data_s;
  logic                 unused_pc_s;

  // Only a slice of the PC feeds the hash; the rest is deliberately ignored
  assign unused_pc_s = ^lk_pc;

  // Index hash: concatenate PC bits with history, or fold history into the PC
  generate
    if (HASH_XOR != 0) begin : g_hash_xor
      assign lk_index = lk_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
    end else if (HIST_BITS == IDX_BITS) begin : g_hash_hist
      assign lk_index = ghr_q;
    end else begin : g_hash_cat
      assign lk_index = {lk_pc[IDX_BITS-HIST_BITS+1:2], ghr_q};
    end
  endgenerate

  // Newest outcome enters at the MSB of the history
  generate
    if (HIST_BITS == 1) begin : g_ghr_one
      assign ghr_shift_s = up_taken;
    end else begin : g_ghr_many
      assign ghr_shift_s = {up_taken, ghr_q[HIST_BITS-1:1]};
    end
  endgenerate

  // Next-state: init sweep owns the write port until it completes, then training
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ghr_d     = ghr_q;
    br_d      = br_q;
    hit_d     = hit_q;
    wr_en_s   = 1'b0;
    wr_addr_s = ptr_q;
    wr_data_s = CTR_INIT;
    case (state_q)
      S_INIT: begin
        wr_en_s   = 1'b1;
        wr_addr_s = ptr_q;
        wr_data_s = CTR_INIT;
        ptr_d     = ptr_q + IDX_BITS'(1'b1);
        if (ptr_q == PTR_LAST) state_d = S_RUN;
        else                   state_d = S_INIT;
      end
      S_RUN: begin
        if (up_valid) begin
          wr_en_s   = 1'b1;
          wr_addr_s = up_index;
          wr_data_s = incdec_sat(tbl_q[up_index], up_taken);
          ghr_d     = ghr_shift_s;
          br_d      = br_q + 32'd1;
          if (up_taken == up_predicted) hit_d = hit_q + 32'd1;
          else                          hit_d = hit_q;
        end else begin
          wr_en_s = 1'b0;
        end
      end
      default: begin
        state_d = S_INIT;
        ptr_d   = '0;
      end
    endcase
  end

  // Control state, history and statistics registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
      ghr_q   <= '0;
      br_q    <= 32'd0;
      hit_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ghr_q   <= ghr_d;
      br_q    <= br_d;
      hit_q   <= hit_d;
    end
  end

  // Pattern table: single write port, no writes while reset is held
  always_ff @(posedge clk) begin
    if (resetn && wr_en_s) tbl_q[wr_addr_s] <= wr_data_s;
  end

  // Direction is the counter MSB, suppressed until the sweep has finished
  always_comb begin
    if (state_q == S_RUN) lk_taken = tbl_q[lk_index][1];
    else                  lk_taken = 1'b0;
  end

  assign ready         = (state_q == S_RUN);
  assign stat_branches = br_q;
  assign stat_hits     = hit_q;

`ifdef BPU_RAS_EN
  bpu_ras #(
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .resetn     (resetn),
    .push_i     (ras_push),
    .push_addr_i(ras_push_addr),
    .pop_i      (ras_pop),
    .target_o   (ras_target),
    .valid_o    (ras_valid)
  );
`else
  localparam int unsigned unused_ras_depth = RAS_DEPTH;
`endif

endmodule

// File: tb/tb_bpu_gshare.sv
// Self-checking bench for bpu_gshare (IDX_BITS=4, HIST_BITS=2, RAS_DEPTH=4).
// Two instances share all inputs: u_dut0 uses the concatenating hash,
// u_dut1 the XOR hash. Lookup expectations come from a reference table
// model and go through a queue before being compared.
module tb_bpu_gshare;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] lk_pc;
  logic        up_valid;
  logic [3:0]  up_index;
  logic        up_taken;
  logic        up_predicted;
  logic        ready0, ready1, tk0, tk1;
  logic [3:0]  idx0, idx1;
  logic [31:0] br0, br1, hit0, hit1;
`ifdef BPU_RAS_EN
  logic        ras_push, ras_pop;
  logic [31:0] ras_push_addr;
  logic [31:0] rt0, rt1;
  logic        rv0, rv1;
`endif

  int errors = 0;
  int checks = 0;

  logic [1:0] mdl_tbl [16];
  logic [1:0] mdl_ghr;
  int         mdl_br, mdl_hit;

  typedef struct {
    logic [3:0] idx0;
    logic [3:0] idx1;
    logic       tk0;
    logic       tk1;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  bpu_gshare #(.HIST_BITS(2), .IDX_BITS(4), .HASH_XOR(0), .CTR_INIT(2'b01), .RAS_DEPTH(4)) u_dut0 (
    .clk(clk), .resetn(resetn), .ready(ready0), .lk_pc(lk_pc), .lk_taken(tk0), .lk_index(idx0),
    .up_valid(up_valid), .up_index(up_index), .up_taken(up_taken), .up_predicted(up_predicted),
    .stat_branches(br0), .stat_hits(hit0)
`ifdef BPU_RAS_EN
    , .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
    .ras_target(rt0), .ras_valid(rv0)
`endif
  );

  bpu_gshare #(.HIST_BITS(2), .IDX_BITS(4), .HASH_XOR(1), .CTR_INIT(2'b01), .RAS_DEPTH(4)) u_dut1 (
    .clk(clk), .resetn(resetn), .ready(ready1), .lk_pc(lk_pc), .lk_taken(tk1), .lk_index(idx1),
    .up_valid(up_valid), .up_index(up_index), .up_taken(up_taken), .up_predicted(up_predicted),
    .stat_branches(br1), .stat_hits(hit1)
`ifdef BPU_RAS_EN
    , .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
    .ras_target(rt1), .ras_valid(rv1)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 16; i++) mdl_tbl[i] = 2'd1;
    mdl_ghr = 2'd0;
    mdl_br  = 0;
    mdl_hit = 0;
  endtask

  task automatic mdl_update(input logic [3:0] idx, input logic t, input logic p);
    if (t) begin
      if (mdl_tbl[idx] != 2'd3) mdl_tbl[idx] = mdl_tbl[idx] + 2'd1;
    end else begin
      if (mdl_tbl[idx] != 2'd0) mdl_tbl[idx] = mdl_tbl[idx] - 2'd1;
    end
    mdl_ghr = {t, mdl_ghr[1]};
    mdl_br++;
    if (t == p) mdl_hit++;
  endtask

  // Resolve one branch for a full clock cycle, then train the model
  task automatic do_update(input logic [3:0] idx, input logic t, input logic p);
    up_valid = 1'b1; up_index = idx; up_taken = t; up_predicted = p;
    tick();
    up_valid = 1'b0;
    mdl_update(idx, t, p);
  endtask

  // Drive a PC that makes the XOR-hash instance look up idx; check both instances
  task automatic lookup_for(input logic [3:0] idx, input string tag);
    logic [3:0] pcf;
    exp_t e;
    pcf = idx ^ {2'b00, mdl_ghr};
    lk_pc = {26'd0, pcf, 2'b00};
    e.idx1 = idx;
    e.idx0 = {pcf[1:0], mdl_ghr};
    e.tk1  = mdl_tbl[idx][1];
    e.tk0  = mdl_tbl[e.idx0][1];
    exp_q.push_back(e);
    #1;
    e = exp_q.pop_front();
    check_eq({tag, ".idx0"}, 32'(idx0), 32'(e.idx0));
    check_eq({tag, ".idx1"}, 32'(idx1), 32'(e.idx1));
    check_eq({tag, ".tk0"},  32'(tk0),  32'(e.tk0));
    check_eq({tag, ".tk1"},  32'(tk1),  32'(e.tk1));
  endtask

  task automatic check_stats(input string tag, input int b, input int h);
    check_eq({tag, ".br0"},  br0,  32'(b));
    check_eq({tag, ".hit0"}, hit0, 32'(h));
    check_eq({tag, ".br1"},  br1,  32'(b));
    check_eq({tag, ".hit1"}, hit1, 32'(h));
  endtask

  task automatic sweep_to_ready(input string tag);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check_eq({tag, ".ready0"}, 32'(ready0), 32'(k == 16));
      check_eq({tag, ".ready1"}, 32'(ready1), 32'(k == 16));
      if (k < 16) check_eq({tag, ".tk_forced"}, 32'(tk0), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    resetn = 1'b0; lk_pc = 32'd0;
    up_valid = 1'b0; up_index = 4'd0; up_taken = 1'b0; up_predicted = 1'b0;
`ifdef BPU_RAS_EN
    ras_push = 1'b0; ras_pop = 1'b0; ras_push_addr = 32'd0;
`endif
    mdl_reset();
    tick(); tick(); tick();

    // Reset values
    check_eq("rst.ready", 32'(ready0), 32'd0);
    check_eq("rst.tk0",   32'(tk0),    32'd0);
    check_eq("rst.tk1",   32'(tk1),    32'd0);
    check_stats("rst", 0, 0);
`ifdef BPU_RAS_EN
    check_eq("rst.ras_valid",  32'(rv0), 32'd0);
    check_eq("rst.ras_target", rt0,      32'd0);
`endif

    // Init sweep: ready after exactly 16 cycles, all counters weakly not-taken
    resetn = 1'b1;
    sweep_to_ready("init");
    for (int i = 0; i < 16; i++) begin
      lookup_for(4'(i), "init_lk");
      tick();
    end

    // Saturation on index 5: 1,2,3,3,3 then 2, then 1
    for (int n = 0; n < 4; n++) begin
      do_update(4'd5, 1'b1, 1'b1);
      lookup_for(4'd5, "sat_up");
    end
    check_eq("sat.taken_after4", 32'(tk1), 32'd1);
    do_update(4'd5, 1'b0, 1'b1);
    lookup_for(4'd5, "sat_dn1");
    check_eq("sat.one_step_down", 32'(tk1), 32'd1);
    do_update(4'd5, 1'b0, 1'b1);
    lookup_for(4'd5, "sat_dn2");
    check_eq("sat.two_steps_down", 32'(tk1), 32'd0);

    // History T then N gives ghr=01; pc 0x8 hashes to 1001 / 0011
    do_update(4'd7, 1'b1, 1'b1);
    do_update(4'd7, 1'b0, 1'b0);
    lk_pc = 32'h8;
    #1;
    check_eq("hash.cat", 32'(idx0), 32'h9);
    check_eq("hash.xor", 32'(idx1), 32'h3);
    tick();

    // Same-cycle lookup and update of index 3 sees the old counter
    up_valid = 1'b1; up_index = 4'd3; up_taken = 1'b1; up_predicted = 1'b0;
    lookup_for(4'd3, "coll_same");
    check_eq("coll.same_cycle", 32'(tk1), 32'd0);
    tick();
    up_valid = 1'b0;
    mdl_update(4'd3, 1'b1, 1'b0);
    lookup_for(4'd3, "coll_next");
    check_eq("coll.next_cycle", 32'(tk1), 32'd1);
    check_stats("stats_run", mdl_br, mdl_hit);

    // Reset in the middle of a sweep with up_valid held high throughout
    resetn = 1'b0;
    tick(); tick();
    check_stats("rst2", 0, 0);
    check_eq("rst2.ready", 32'(ready0), 32'd0);
    resetn = 1'b1;
    up_valid = 1'b1; up_index = 4'd2; up_taken = 1'b1; up_predicted = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    check_eq("midinit.ready", 32'(ready0), 32'd0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    sweep_to_ready("reinit");
    up_valid = 1'b0;
    mdl_reset();
    check_stats("init_ignores_up", 0, 0);
    lookup_for(4'd2, "reinit_lk2");
    lookup_for(4'd5, "reinit_lk5");
    tick();

    // Ten resolutions, seven of them predicted correctly
    for (int i = 0; i < 10; i++) begin
      do_update(4'(i), 1'(i % 2), (i < 7) ? 1'(i % 2) : ~1'(i % 2));
      lookup_for(4'(i), "stat_lk");
    end
    check_stats("stats10", 10, 7);
    check_stats("stats10_mdl", mdl_br, mdl_hit);

`ifdef BPU_RAS_EN
    // Five pushes into a 4-deep stack, then drain
    for (int i = 0; i < 5; i++) begin
      ras_push = 1'b1; ras_push_addr = 32'h100 + 32'(4 * i);
      tick();
      ras_push = 1'b0;
      check_eq("ras.push_top", rt0, 32'h100 + 32'(4 * i));
      check_eq("ras.push_valid", 32'(rv0), 32'd1);
    end
    ras_pop = 1'b1; tick(); ras_pop = 1'b0;
    check_eq("ras.pop1", rt0, 32'h10C);
    ras_pop = 1'b1; tick(); ras_pop = 1'b0;
    check_eq("ras.pop2", rt0, 32'h108);
    ras_pop = 1'b1; tick(); ras_pop = 1'b0;
    check_eq("ras.pop3", rt0, 32'h104);
    ras_pop = 1'b1; tick(); ras_pop = 1'b0;
    check_eq("ras.pop4_valid", 32'(rv0), 32'd0);
    ras_pop = 1'b1; tick(); ras_pop = 1'b0;
    check_eq("ras.pop_empty_valid", 32'(rv0), 32'd0);
    // Push then push+pop: top replaced, count stays 1
    ras_push = 1'b1; ras_push_addr = 32'h300; tick();
    ras_pop = 1'b1; ras_push_addr = 32'h200; tick();
    ras_push = 1'b0; ras_pop = 1'b0;
    check_eq("ras.replace_top", rt0, 32'h200);
    check_eq("ras.replace_valid", 32'(rv1), 32'd1);
    ras_pop = 1'b1; tick(); ras_pop = 1'b0;
    check_eq("ras.replace_count1", 32'(rv0), 32'd0);
    // push+pop on empty stack leaves one entry
    ras_push = 1'b1; ras_pop = 1'b1; ras_push_addr = 32'h400; tick();
    ras_push = 1'b0; ras_pop = 1'b0;
    check_eq("ras.pp_empty_valid", 32'(rv0), 32'd1);
    check_eq("ras.pp_empty_top", rt0, 32'h400);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
